// File: rtl/updown_counter_n.sv
// Parametrised up/down modulo counter with clear, load, terminal flag and wrap pulse.
// Optional saturating mode (adds the saturate input) when COUNTER_SATURATE_EN is defined.
module updown_counter_n #(
    parameter int     WIDTH   = 6,
    parameter longint MODULUS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
`ifdef COUNTER_SATURATE_EN
    input  logic             saturate,
`endif
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrap
);

    if (WIDTH < 1 || MODULUS < 2 || (WIDTH < 62 && MODULUS > (longint'(1) << WIDTH))) begin : g_bad_params
        $error("updown_counter_n: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);

    logic             at_top;
    logic             at_bottom;
    logic             sat_hold;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;

`ifdef COUNTER_SATURATE_EN
    assign sat_hold = saturate;
`else
    assign sat_hold = 1'b0;
`endif

    assign at_top    = (count == MAX_COUNT);
    assign at_bottom = (count == '0);
    assign terminal  = up ? at_top : at_bottom;

    // Out-of-range load values clamp to the top of the range so count stays below MODULUS.
    assign load_clamped = ({1'b0, load_value} < MOD_EXT) ? load_value : MAX_COUNT;

    always_comb begin
        step = count;
        if (up) begin
            step = at_top ? '0 : count + WIDTH'(1);
        end else begin
            step = at_bottom ? MAX_COUNT : count - WIDTH'(1);
        end
    end

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable) begin
            // In saturating mode a step past the bound holds count but still pulses wrap.
            wrap_d = terminal;
            if (!(terminal && sat_hold)) begin
                count_d = step;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed self-checking bench for updown_counter_n (MODULUS 32, 10 and 2^WIDTH instances).
module tb_updown_counter_n;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b1;
    logic       saturate = 1'b0;
    logic [5:0] lv32 = '0;
    logic [3:0] lv10 = '0;
    logic [2:0] lv8 = '0;

    logic [5:0] count32;
    logic [3:0] count10;
    logic [2:0] count8;
    logic       term32, term10, term8;
    logic       wrap32, wrap10, wrap8;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    updown_counter_n #(.WIDTH(6), .MODULUS(32)) u_d32 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(lv32), .up(up),
`ifdef COUNTER_SATURATE_EN
        .saturate(saturate),
`endif
        .count(count32), .terminal(term32), .wrap(wrap32)
    );

    updown_counter_n #(.WIDTH(4), .MODULUS(10)) u_d10 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(lv10), .up(up),
`ifdef COUNTER_SATURATE_EN
        .saturate(saturate),
`endif
        .count(count10), .terminal(term10), .wrap(wrap10)
    );

    updown_counter_n #(.WIDTH(3), .MODULUS(8)) u_d8 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .load_value(lv8), .up(up),
`ifdef COUNTER_SATURATE_EN
        .saturate(saturate),
`endif
        .count(count8), .terminal(term8), .wrap(wrap8)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic dir);
        enable = 1'b0; clear = 1'b0; load = 1'b0; up = dir; saturate = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; up = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
        #1;
        checks++;
        if (count32 !== 6'd0 || wrap32 !== 1'b0 || term32 !== 1'b0) begin
            failures++;
            $display("FAIL reset_up: count=%0d wrap=%b term=%b expected count=0 wrap=0 term=0", count32, wrap32, term32);
        end
        up = 1'b0;
        #1;
        checks++;
        if (term32 !== 1'b1 || term10 !== 1'b1 || count10 !== 4'd0) begin
            failures++;
            $display("FAIL reset_down_terminal: term32=%b term10=%b count10=%0d expected 1 1 0", term32, term10, count10);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_count_up32;
        logic [5:0] exp;
        do_reset(1'b1);
        enable = 1'b1;
        exp = 6'd0;
        for (int i = 1; i <= 33; i++) begin
            checks++;
            if (term32 !== (exp == 6'd31)) begin
                failures++;
                $display("FAIL up32_terminal step %0d: term=%b expected %b (count=%0d)", i, term32, exp == 6'd31, count32);
            end
            tick();
            exp = (exp == 6'd31) ? 6'd0 : exp + 6'd1;
            checks++;
            if (count32 !== exp || wrap32 !== (i == 32)) begin
                failures++;
                $display("FAIL up32_count step %0d: count=%0d wrap=%b expected count=%0d wrap=%b", i, count32, wrap32, exp, i == 32);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_count_down10;
        logic [3:0] seq [11] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
        logic [3:0] cur;
        do_reset(1'b0);
        enable = 1'b1;
        cur = 4'd0;
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (term10 !== (cur == 4'd0)) begin
                failures++;
                $display("FAIL down10_terminal step %0d: term=%b expected %b", i, term10, cur == 4'd0);
            end
            tick();
            cur = seq[i];
            checks++;
            if (count10 !== cur || wrap10 !== (i == 0 || i == 10)) begin
                failures++;
                $display("FAIL down10_count step %0d: count=%0d wrap=%b expected count=%0d wrap=%b", i, count10, wrap10, cur, (i == 0 || i == 10));
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_clear;
        do_reset(1'b1);
        enable = 1'b1; load = 1'b1; lv32 = 6'd5; lv10 = 4'd12;
        tick();
        checks++;
        if (count32 !== 6'd5 || wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL load5: count=%0d wrap=%b expected 5 0", count32, wrap32);
        end
        checks++;
        if (count10 !== 4'd9) begin
            failures++;
            $display("FAIL load_clamp10: count=%0d expected 9", count10);
        end
        clear = 1'b1;
        tick();
        checks++;
        if (count32 !== 6'd0 || wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL clear_over_load: count=%0d wrap=%b expected 0 0", count32, wrap32);
        end
        clear = 1'b0; lv32 = 6'd40;
        tick();
        checks++;
        if (count32 !== 6'd31) begin
            failures++;
            $display("FAIL load_clamp32: count=%0d expected 31", count32);
        end
        // At terminal with enable high, a load must suppress the wrap.
        lv32 = 6'd2;
        tick();
        checks++;
        if (count32 !== 6'd2 || wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL load_suppress_wrap: count=%0d wrap=%b expected 2 0", count32, wrap32);
        end
        lv32 = 6'd31;
        tick();
        load = 1'b0; clear = 1'b1;
        tick();
        checks++;
        if (count32 !== 6'd0 || wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL clear_suppress_wrap: count=%0d wrap=%b expected 0 0", count32, wrap32);
        end
        clear = 1'b0; enable = 1'b0;
        tick();
        tick();
        checks++;
        if (count32 !== 6'd0 || wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL hold: count=%0d wrap=%b expected 0 0", count32, wrap32);
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b1);
        enable = 1'b1;
        repeat (17) tick();
        checks++;
        if (count32 !== 6'd17) begin
            failures++;
            $display("FAIL pre_reset_count: count=%0d expected 17", count32);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (count32 !== 6'd0 || wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: count=%0d wrap=%b expected 0 0", count32, wrap32);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        checks++;
        if (count32 !== 6'd0) begin
            failures++;
            $display("FAIL resume0: count=%0d expected 0", count32);
        end
        tick();
        checks++;
        if (count32 !== 6'd1) begin
            failures++;
            $display("FAIL resume1: count=%0d expected 1", count32);
        end
        tick();
        checks++;
        if (count32 !== 6'd2) begin
            failures++;
            $display("FAIL resume2: count=%0d expected 2", count32);
        end
        enable = 1'b0; load = 1'b1; lv32 = 6'd31;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        checks++;
        if (count32 !== 6'd0 || wrap32 !== 1'b1) begin
            failures++;
            $display("FAIL wrap_before_reset: count=%0d wrap=%b expected 0 1", count32, wrap32);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_cut_by_reset: wrap=%b expected 0", wrap32);
        end
        @(posedge clock);
        #1;
        reset = 1'b0; enable = 1'b0;
    endtask

    task automatic test_toggle_dir;
        logic [5:0] seq [4] = '{6'd4, 6'd3, 6'd4, 6'd3};
        do_reset(1'b1);
        load = 1'b1; lv32 = 6'd3;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            tick();
            checks++;
            if (count32 !== seq[i] || wrap32 !== 1'b0) begin
                failures++;
                $display("FAIL toggle step %0d: count=%0d wrap=%b expected count=%0d wrap=0", i, count32, wrap32, seq[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_pow2;
        logic [2:0] seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        do_reset(1'b1);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count8 !== seq[i] || wrap8 !== (i == 7)) begin
                failures++;
                $display("FAIL pow2_up step %0d: count=%0d wrap=%b expected count=%0d wrap=%b", i, count8, wrap8, seq[i], i == 7);
            end
        end
        up = 1'b0;
        #1;
        checks++;
        if (term8 !== 1'b1) begin
            failures++;
            $display("FAIL pow2_terminal: term=%b expected 1", term8);
        end
        tick();
        checks++;
        if (count8 !== 3'd7 || wrap8 !== 1'b1) begin
            failures++;
            $display("FAIL pow2_down: count=%0d wrap=%b expected 7 1", count8, wrap8);
        end
        enable = 1'b0;
    endtask

`ifdef COUNTER_SATURATE_EN
    task automatic test_saturate;
        do_reset(1'b1);
        saturate = 1'b1; load = 1'b1; lv32 = 6'd40;
        tick();
        checks++;
        if (count32 !== 6'd31 || wrap32 !== 1'b0) begin
            failures++;
            $display("FAIL sat_load_clamp: count=%0d wrap=%b expected 31 0", count32, wrap32);
        end
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count32 !== 6'd31 || wrap32 !== 1'b1) begin
                failures++;
                $display("FAIL sat_up step %0d: count=%0d wrap=%b expected 31 1", i, count32, wrap32);
            end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count32 !== 6'd0 || wrap32 !== 1'b1) begin
                failures++;
                $display("FAIL sat_down step %0d: count=%0d wrap=%b expected 0 1", i, count32, wrap32);
            end
        end
        saturate = 1'b0; enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up32();
        test_count_down10();
        test_load_clear();
        test_async_reset();
        test_toggle_dir();
        test_pow2();
`ifdef COUNTER_SATURATE_EN
        test_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
